// File: rtl/jtkicker_obj_romslot.sv
// ============================================================================
// Module   : jtkicker_obj_romslot
// Brief    : One-entry 32-bit word cache for the object engine. A miss is
//            filled as two 16-bit SDRAM reads (low half, then high half).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jtkicker_obj_romslot #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    input  logic          dwn,
    output logic          sdram_req,
    output logic [AW:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        DAT0 = 3'd2,
        REQ1 = 3'd3,
        DAT1 = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_tag;
    logic [AW-1:0] r_pend;
    logic          r_valid;
    logic [31:0]   r_data;
    logic          r_sdram_req;
    logic [AW:0]   r_sdram_addr;
    logic          r_dwn_seen;

    logic          w_hit;
    logic          w_start;
    logic          w_ack_take;
    logic          w_lo_load;
    logic          w_hi_load;

    assign w_hit      = r_valid & (r_tag == rom_addr);
    assign rom_ok     = rom_cs & w_hit & ~dwn;
    assign rom_data   = r_data;
    assign sdram_req  = r_sdram_req;
    assign sdram_addr = r_sdram_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acks and strobes only count in the state that waits for them.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack_take  = 1'b0;
        w_lo_load   = 1'b0;
        w_hi_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rom_cs && !w_hit && !dwn) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ0;
                end
            end
            REQ0: begin
                if (sdram_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = DAT0;
                end
            end
            DAT0: begin
                if (sdram_dst) begin
                    w_lo_load   = 1'b1;
                    w_state_nxt = REQ1;
                end
            end
            REQ1: begin
                if (sdram_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = DAT1;
                end
            end
            DAT1: begin
                if (sdram_dst) begin
                    w_hi_load   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_pend       <= '0;
        end else begin
            if (w_start) begin
                r_pend       <= rom_addr;
                r_sdram_addr <= {rom_addr, 1'b0};
                r_sdram_req  <= 1'b1;
            end
            if (w_ack_take) begin
                r_sdram_req <= 1'b0;
            end
            if (w_lo_load) begin
                r_sdram_addr[0] <= 1'b1;
                r_sdram_req     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_tag  <= '0;
        end else begin
            if (w_lo_load) begin
                r_data[15:0] <= sdram_din;
            end
            if (w_hi_load) begin
                r_data[31:16] <= sdram_din;
                r_tag         <= r_pend;
            end
        end
    end

    // A download seen at any point of a fetch taints the word it returns,
    // even if dwn has already dropped again when the fill lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwn_seen <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_start) begin
                r_dwn_seen <= 1'b0;
            end else if (dwn && r_state != IDLE) begin
                r_dwn_seen <= 1'b1;
            end
            if (dwn || w_start) begin
                r_valid <= 1'b0;
            end else if (w_hi_load) begin
                r_valid <= ~r_dwn_seen;
            end
        end
    end

endmodule

`default_nettype wire
